lcd_layer_compositor: RTL and testbench

Parametrised LCD timing generator and pixel compositor for the 800x480 RGB565 panel. Drives DEN/HSYNC/VSYNC/CLK. Composites a background ramp ROM, NUM_SPRITES ARGB1555 sprite layers and an optional test border. Sprite positions are double-buffered and update only at frame boundaries, so there is no tearing. Sync and DEN are pipeline-aligned with the pixel data. Sits between the MCU offset registers and the panel pins.

---
 rtl/lcd_layer_compositor.sv | 165 ++++++++++++++++
 tb/tb_lcd_layer_compositor.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_layer_compositor.sv
// LCD raster timing plus compositor: background ramp ROM, ARGB1555 sprite layers, optional white border.
// Latency: raster counters to panel pins is 2 clk_pix cycles; DEN, HSYNC, VSYNC and RGB are aligned.
// Backpressure: none; the panel takes one pixel every clock, and the ROMs answer in exactly one clock.
module lcd_layer_compositor #(
  parameter int H_DATA      = 800,
  parameter int H_BP        = 46,
  parameter int H_FP        = 294,
  parameter int H_PULSE     = 1,
  parameter int V_DATA      = 480,
  parameter int V_BP        = 23,
  parameter int V_FP        = 23,
  parameter int V_PULSE     = 5,
  parameter int NUM_SPRITES = 2,
  parameter int SPR_LOG2    = 6,
  parameter int BORDER_EN   = 1
) (
  input  logic                                clk_pix,
  input  logic                                reset,
  output logic                                lcd_clk,
  output logic                                lcd_den,
  output logic                                lcd_hsync,
  output logic                                lcd_vsync,
  output logic [4:0]                          lcd_r,
  output logic [5:0]                          lcd_g,
  output logic [4:0]                          lcd_b,
  input  logic [16*NUM_SPRITES-1:0]           spr_x_in,
  input  logic [16*NUM_SPRITES-1:0]           spr_y_in,
  input  logic [NUM_SPRITES-1:0]              spr_en_in,
  output logic [7:0]                          bg_addr,
  input  logic [15:0]                         bg_data,
  output logic [2*SPR_LOG2*NUM_SPRITES-1:0]   spr_addr,
  input  logic [16*NUM_SPRITES-1:0]           spr_data,
  output logic                                frame_int
);
  localparam int H_TOTAL = H_BP + H_DATA + H_FP;
  localparam int V_TOTAL = V_BP + V_DATA + V_FP;
  localparam int AW      = 2 * SPR_LOG2;

  typedef logic signed [16:0] diff_t;

  // raster counters and the active (shadowed) sprite registers
  logic [15:0]               h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [16*NUM_SPRITES-1:0] spr_x_q, spr_x_d, spr_y_q, spr_y_d;
  logic [NUM_SPRITES-1:0]    spr_en_q, spr_en_d;
  logic                      frame_int_q, frame_int_d;
  logic                      frame_end;

  // stage 1: travels alongside the ROM read
  logic [NUM_SPRITES-1:0]    hit_q, hit_d;
  logic                      border_q, border_d, den1_q, den1_d, hs1_q, hs1_d, vs1_q, vs1_d;

  // stage 2: pin registers
  logic                      den_q, den_d, hs_q, hs_d, vs_q, vs_d;
  logic [15:0]               rgb_q, rgb_d;

  // stage 0 intermediates
  logic signed [15:0]        x_pos, y_pos;
  logic                      x_en, y_en;
  diff_t                     dx [NUM_SPRITES];
  diff_t                     dy [NUM_SPRITES];
  logic [15:0]               pix;

  // Raster advance; sprite registers reload only on the very last clock of a frame so a frame never tears
  always_comb begin
    frame_end = (h_cnt_q == 16'(H_TOTAL - 1)) && (v_cnt_q == 16'(V_TOTAL - 1));
    h_cnt_d   = h_cnt_q + 16'd1;
    v_cnt_d   = v_cnt_q;
    if (h_cnt_q == 16'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == 16'(V_TOTAL - 1)) ? '0 : v_cnt_q + 16'd1;
    end
    spr_x_d     = frame_end ? spr_x_in  : spr_x_q;
    spr_y_d     = frame_end ? spr_y_in  : spr_y_q;
    spr_en_d    = frame_end ? spr_en_in : spr_en_q;
    frame_int_d = frame_end;
  end

  // Stage 0: active-area flags, syncs and ROM addresses straight from the counters
  always_comb begin
    x_pos    = $signed(h_cnt_q - 16'(H_BP));
    y_pos    = $signed(v_cnt_q - 16'(V_BP));
    x_en     = (h_cnt_q >= 16'(H_BP)) && (h_cnt_q < 16'(H_BP + H_DATA));
    y_en     = (v_cnt_q >= 16'(V_BP)) && (v_cnt_q < 16'(V_BP + V_DATA));
    den1_d   = x_en && y_en;
    hs1_d    = (h_cnt_q >= 16'(H_PULSE));
    vs1_d    = (v_cnt_q >= 16'(V_PULSE));
    border_d = (BORDER_EN != 0) && x_en && y_en &&
               ((h_cnt_q == 16'(H_BP)) || (h_cnt_q == 16'(H_BP + H_DATA - 1)) ||
                (v_cnt_q == 16'(V_BP)) || (v_cnt_q == 16'(V_BP + V_DATA - 1)));
    bg_addr  = y_pos[7:0];
    hit_d    = '0;
    spr_addr = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      // 17-bit differences so a far-negative sprite cannot alias into range
      dx[i]    = {x_pos[15], x_pos} - {spr_x_q[16*i+15], spr_x_q[16*i +: 16]};
      dy[i]    = {y_pos[15], y_pos} - {spr_y_q[16*i+15], spr_y_q[16*i +: 16]};
      hit_d[i] = spr_en_q[i] && (dx[i][16:SPR_LOG2] == '0) && (dy[i][16:SPR_LOG2] == '0);
      if (hit_d[i]) begin
        spr_addr[AW*i +: AW] = {dy[i][SPR_LOG2-1:0], dx[i][SPR_LOG2-1:0]};
      end
    end
  end

  // Stage 2: layer priority is border, then lowest-index opaque sprite, then background
  always_comb begin
    pix = bg_data;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_q[i] && spr_data[16*i+15]) begin
        pix = {spr_data[16*i+10 +: 5], spr_data[16*i+5 +: 5], 1'b0, spr_data[16*i +: 5]};
      end
    end
    if (border_q) pix = 16'hFFFF;
    rgb_d = den1_q ? pix : 16'h0000;
    den_d = den1_q;
    hs_d  = hs1_q;
    vs_d  = vs1_q;
  end

  // All state; reset puts the pins in their idle levels and hides every sprite until the first reload
  always_ff @(posedge clk_pix or negedge reset) begin
    if (!reset) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      spr_x_q     <= '0;
      spr_y_q     <= '0;
      spr_en_q    <= '0;
      frame_int_q <= 1'b0;
      hit_q       <= '0;
      border_q    <= 1'b0;
      den1_q      <= 1'b0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      den_q       <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      rgb_q       <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      spr_x_q     <= spr_x_d;
      spr_y_q     <= spr_y_d;
      spr_en_q    <= spr_en_d;
      frame_int_q <= frame_int_d;
      hit_q       <= hit_d;
      border_q    <= border_d;
      den1_q      <= den1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      den_q       <= den_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      rgb_q       <= rgb_d;
    end
  end

  assign lcd_clk   = ~clk_pix;
  assign lcd_den   = den_q;
  assign lcd_hsync = hs_q;
  assign lcd_vsync = vs_q;
  assign lcd_r     = rgb_q[15:11];
  assign lcd_g     = rgb_q[10:5];
  assign lcd_b     = rgb_q[4:0];
  assign frame_int = frame_int_q;

endmodule

// File: tb/tb_lcd_layer_compositor.sv
// Bench for lcd_layer_compositor on a shrunken raster: per-cycle scoreboard of pins, addresses and frame pulse,
// plus a table of sprite scenarios probed at single pixels, a mid-frame position change and a mid-frame reset.
// Bench ROMs answer one clock after the address, as the real ROMs do.
module tb_lcd_layer_compositor;
  localparam int H_DATA = 16, H_BP = 4, H_FP = 5, H_PULSE = 2;
  localparam int V_DATA = 12, V_BP = 3, V_FP = 2, V_PULSE = 2;
  localparam int NSPR = 2, SPR_LOG2 = 2, SPR = 4;
  localparam int H_TOTAL = H_BP + H_DATA + H_FP;
  localparam int V_TOTAL = V_BP + V_DATA + V_FP;
  localparam int FRAME = H_TOTAL * V_TOTAL;

  logic        clk_pix, reset;
  logic        lcd_clk, lcd_den, lcd_hsync, lcd_vsync, frame_int;
  logic [4:0]  lcd_r, lcd_b;
  logic [5:0]  lcd_g;
  logic [31:0] spr_x_in, spr_y_in, spr_data;
  logic [1:0]  spr_en_in, alpha_en;
  logic [7:0]  bg_addr, spr_addr;
  logic [15:0] bg_data;

  lcd_layer_compositor #(
    .H_DATA(H_DATA), .H_BP(H_BP), .H_FP(H_FP), .H_PULSE(H_PULSE),
    .V_DATA(V_DATA), .V_BP(V_BP), .V_FP(V_FP), .V_PULSE(V_PULSE),
    .NUM_SPRITES(NSPR), .SPR_LOG2(SPR_LOG2), .BORDER_EN(1)
  ) dut (
    .clk_pix(clk_pix), .reset(reset), .lcd_clk(lcd_clk), .lcd_den(lcd_den),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .spr_x_in(spr_x_in), .spr_y_in(spr_y_in), .spr_en_in(spr_en_in),
    .bg_addr(bg_addr), .bg_data(bg_data), .spr_addr(spr_addr), .spr_data(spr_data),
    .frame_int(frame_int)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  // sprite 0 is red with blue = address, sprite 1 is green with blue = address
  function automatic logic [15:0] rom_word(input int i, input int a);
    if (i == 0) return {alpha_en[0], 15'h7C00 | 15'(a)};
    return {alpha_en[1], 15'h03E0 | 15'(a)};
  endfunction

  always @(posedge clk_pix) begin
    bg_data         <= 16'h1000 + 16'(bg_addr);
    spr_data[15:0]  <= rom_word(0, int'(spr_addr[3:0]));
    spr_data[31:16] <= rom_word(1, int'(spr_addr[7:4]));
  end

  typedef struct {
    logic den, hs, vs;
    logic [15:0] rgb;
    int x, y;
  } exp_t;

  typedef struct {
    logic signed [15:0] sx0, sy0, sx1, sy1;
    logic [1:0] en, alpha;
    int px, py;
    logic [15:0] exp_rgb;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];
  int checks = 0, failures = 0;
  int hm, vm, cyc, last_fi, hs_run, vs_run;
  int asx[NSPR], asy[NSPR];
  logic [1:0] aen;
  logic prev_fe;
  logic probe_on, probe_hit;
  int probe_x, probe_y;
  logic [15:0] probe_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (model h=%0d v=%0d)", name, act, exp, hm, vm);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired (model h=%0d v=%0d)", name, hm, vm);
  endtask

  function automatic logic in_spr(input int i, input int x, input int y);
    return aen[i] && x >= asx[i] && x < asx[i] + SPR && y >= asy[i] && y < asy[i] + SPR;
  endfunction

  function automatic exp_t model_pix(input int hc, input int vc);
    exp_t e;
    logic [15:0] rom;
    logic done;
    int x, y;
    x = hc - H_BP;
    y = vc - V_BP;
    e.x = x;
    e.y = y;
    e.den = (x >= 0 && x < H_DATA && y >= 0 && y < V_DATA);
    e.hs = (hc >= H_PULSE);
    e.vs = (vc >= V_PULSE);
    e.rgb = 16'h1000 + 16'(y & 255);
    done = 1'b0;
    for (int i = 0; i < NSPR; i++) begin
      if (!done && in_spr(i, x, y)) begin
        rom = rom_word(i, (y - asy[i]) * SPR + (x - asx[i]));
        if (rom[15]) begin
          e.rgb = {rom[14:10], rom[9:5], 1'b0, rom[4:0]};
          done = 1'b1;
        end
      end
    end
    if (x == 0 || x == H_DATA - 1 || y == 0 || y == V_DATA - 1) e.rgb = 16'hFFFF;
    if (!e.den) e.rgb = 16'h0000;
    return e;
  endfunction

  function automatic logic [7:0] model_addr(input int hc, input int vc);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < NSPR; i++) begin
      if (in_spr(i, hc - H_BP, vc - V_BP))
        r[4*i +: 4] = 4'((vc - V_BP - asy[i]) * SPR + (hc - H_BP - asx[i]));
    end
    return r;
  endfunction

  // one pixel clock: called at a negedge, checks this cycle, then waits for the next negedge
  task automatic step();
    exp_t e, p;
    logic fe;
    e = model_pix(hm, vm);
    sb.push_back(e);
    chk("spr_addr", {24'h0, spr_addr}, {24'h0, model_addr(hm, vm)});
    chk("bg_addr", {24'h0, bg_addr}, {24'h0, 8'((vm - V_BP) & 255)});
    chk("lcd_clk", {31'h0, lcd_clk}, {31'h0, ~clk_pix});
    if (sb.size() > 2) begin
      p = sb.pop_front();
      chk("pins", {13'h0, lcd_den, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b},
                  {13'h0, p.den, p.hs, p.vs, p.rgb});
      if (probe_on && p.den && p.x == probe_x && p.y == probe_y) begin
        probe_hit = 1'b1;
        probe_val = {lcd_r, lcd_g, lcd_b};
        probe_on  = 1'b0;
      end
    end
    chk("frame_int", {31'h0, frame_int}, {31'h0, prev_fe});
    if (frame_int === 1'b1) begin
      chk("frame_int_period", cyc - last_fi, FRAME);
      last_fi = cyc;
    end
    if (lcd_hsync === 1'b0) hs_run++;
    else begin
      if (hs_run != 0) chk("hsync_low_width", hs_run, H_PULSE);
      hs_run = 0;
    end
    if (lcd_vsync === 1'b0) vs_run++;
    else begin
      if (vs_run != 0) chk("vsync_low_width", vs_run, V_PULSE * H_TOTAL);
      vs_run = 0;
    end
    fe = (hm == H_TOTAL - 1) && (vm == V_TOTAL - 1);
    if (fe) begin
      for (int i = 0; i < NSPR; i++) begin
        asx[i] = $signed(spr_x_in[16*i +: 16]);
        asy[i] = $signed(spr_y_in[16*i +: 16]);
      end
      aen = spr_en_in;
    end
    prev_fe = fe;
    if (hm == H_TOTAL - 1) begin
      hm = 0;
      vm = (vm == V_TOTAL - 1) ? 0 : vm + 1;
    end else hm++;
    cyc++;
    @(negedge clk_pix);
  endtask

  task automatic do_release();
    exp_t r;
    reset = 1'b1;
    sb.delete();
    r.den = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.rgb = 16'h0; r.x = -1000; r.y = -1000;
    sb.push_back(r);
    sb.push_back(r);
    hm = 0; vm = 0; cyc = 0; last_fi = 0; hs_run = 0; vs_run = 0;
    aen = 2'b00; prev_fe = 1'b0;
    for (int i = 0; i < NSPR; i++) begin asx[i] = 0; asy[i] = 0; end
  endtask

  task automatic wait_frame_end();
    int n = 0;
    while (!(hm == H_TOTAL - 1 && vm == V_TOTAL - 1) && n < 2 * FRAME) begin step(); n++; end
    if (!(hm == H_TOTAL - 1 && vm == V_TOTAL - 1)) fail_now("wait_frame_end");
  endtask

  task automatic run_probe(input int px, input int py);
    int n = 0;
    probe_x = px; probe_y = py; probe_hit = 1'b0; probe_on = 1'b1;
    while (!probe_hit && n < 2 * FRAME) begin step(); n++; end
    probe_on = 1'b0;
    if (!probe_hit) fail_now("probe_timeout");
  endtask

  task automatic chk_reset_pins(input string name);
    chk(name, {12'h0, lcd_den, lcd_hsync, lcd_vsync, lcd_r, lcd_g, lcd_b, frame_int},
              {12'h0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0});
  endtask

  initial begin
    int n;
    vecs[0]  = '{16'sd5,  16'sd3,  16'sd0,  16'sd0, 2'b01, 2'b11, 5,  3,  16'hF800};
    vecs[1]  = '{16'sd5,  16'sd3,  16'sd0,  16'sd0, 2'b01, 2'b11, 4,  3,  16'h1003};
    vecs[2]  = '{16'sd5,  16'sd3,  16'sd0,  16'sd0, 2'b01, 2'b11, 8,  6,  16'hF80F};
    vecs[3]  = '{16'sd5,  16'sd3,  16'sd0,  16'sd0, 2'b01, 2'b11, 9,  6,  16'h1006};
    vecs[4]  = '{-16'sd1, -16'sd2, 16'sd0,  16'sd0, 2'b01, 2'b11, 1,  1,  16'hF80E};
    vecs[5]  = '{-16'sd1, -16'sd2, 16'sd0,  16'sd0, 2'b01, 2'b11, 0,  1,  16'hFFFF};
    vecs[6]  = '{-16'sd1, -16'sd2, 16'sd0,  16'sd0, 2'b01, 2'b11, 3,  1,  16'h1001};
    vecs[7]  = '{16'sd6,  16'sd4,  16'sd7,  16'sd5, 2'b11, 2'b11, 7,  5,  16'hF805};
    vecs[8]  = '{16'sd6,  16'sd4,  16'sd7,  16'sd5, 2'b11, 2'b10, 7,  5,  16'h07C0};
    vecs[9]  = '{16'sd6,  16'sd4,  16'sd7,  16'sd5, 2'b00, 2'b11, 7,  5,  16'h1005};
    vecs[10] = '{16'sd0,  16'sd0,  16'sd12, 16'sd8, 2'b10, 2'b11, 15, 8,  16'hFFFF};
    vecs[11] = '{16'sd0,  16'sd0,  16'sd12, 16'sd8, 2'b10, 2'b11, 14, 10, 16'h07CA};
    vecs[12] = '{16'sd14, 16'sd10, 16'sd0,  16'sd0, 2'b01, 2'b11, 14, 10, 16'hF800};
    vecs[13] = '{-16'sd4, 16'sd0,  16'sd0,  16'sd0, 2'b01, 2'b11, 1,  1,  16'h1001};

    probe_on = 1'b0; probe_hit = 1'b0; probe_x = 0; probe_y = 0; probe_val = '0;
    hm = 0; vm = 0; cyc = 0; last_fi = 0; hs_run = 0; vs_run = 0; aen = '0; prev_fe = 1'b0;
    reset = 1'b0;
    alpha_en = 2'b11;
    spr_x_in = {16'sd0, 16'sd5};
    spr_y_in = {16'sd0, 16'sd3};
    spr_en_in = 2'b01;
    repeat (3) @(negedge clk_pix);
    chk_reset_pins("reset_state");
    do_release();

    // free run: first frame has no sprites, later frames draw sprite 0 at (5,3)
    repeat (3 * FRAME) step();

    foreach (vecs[k]) begin
      wait_frame_end();
      spr_x_in  = {vecs[k].sx1, vecs[k].sx0};
      spr_y_in  = {vecs[k].sy1, vecs[k].sy0};
      spr_en_in = vecs[k].en;
      alpha_en  = vecs[k].alpha;
      step();
      run_probe(vecs[k].px, vecs[k].py);
      if (probe_hit) chk($sformatf("vec%0d", k), {16'h0, probe_val}, {16'h0, vecs[k].exp_rgb});
    end

    // position change in the middle of a frame must wait for the next frame
    wait_frame_end();
    spr_x_in = {16'sd0, 16'sd2};
    spr_y_in = {16'sd0, 16'sd7};
    spr_en_in = 2'b01;
    alpha_en = 2'b11;
    step();
    n = 0;
    while (vm != V_BP + 6 && n < 2 * FRAME) begin step(); n++; end
    if (vm != V_BP + 6) fail_now("wait_line6");
    spr_x_in[15:0] = 16'd10;
    run_probe(3, 8);
    if (probe_hit) chk("midframe_old_pos", {16'h0, probe_val}, {16'h0, 16'hF805});
    run_probe(11, 8);
    if (probe_hit) chk("midframe_new_not_yet", {16'h0, probe_val}, {16'h0, 16'h1008});
    run_probe(3, 8);
    if (probe_hit) chk("nextframe_old_gone", {16'h0, probe_val}, {16'h0, 16'h1008});
    run_probe(11, 8);
    if (probe_hit) chk("nextframe_new_pos", {16'h0, probe_val}, {16'h0, 16'hF805});

    // asynchronous reset in the middle of the active area
    n = 0;
    while (vm != V_BP + 7 && n < 2 * FRAME) begin step(); n++; end
    if (vm != V_BP + 7) fail_now("wait_line7");
    reset = 1'b0;
    #1;
    chk_reset_pins("reset_async");
    repeat (5) begin
      @(negedge clk_pix);
      chk_reset_pins("reset_hold");
    end
    do_release();
    repeat (FRAME + 10) step();
    chk("frame_int_after_reset", last_fi, FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
